// File: rtl/sram_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sram_frame_sequencer
//  Purpose  : Shares one dual-chip async SRAM bus between the capture write
//             stream and the playback read stream using fixed slots: even
//             cycles write, odd cycles read. A small FIFO on each side
//             decouples the pixel streams from the slot timing.
//  Options  : PING_PONG_EN - double-buffer across the two chips so playback
//             reads the chip that is not being recorded.
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Small synchronous FIFO with flush; head word is presented combinationally.
// ----------------------------------------------------------------------------
module sram_frame_sequencer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign dout    = mem[head];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only accepted when a pop frees a slot.
  assign do_push = push && (!full || do_pop);

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[tail] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO at once.
  always_ff @(posedge clk_in) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// ----------------------------------------------------------------------------
// Top level: slot scheduler, record/play FSMs, frame pointers, bank select.
// ----------------------------------------------------------------------------
module sram_frame_sequencer #(
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 8,
  parameter int FRAME_WORDS = 1228800,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              rec_en,
  input  logic              play_en,
  input  logic              frame_start,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] io_out,
  output logic              io_oe,
  input  logic [DATA_W-1:0] io_in,
  output logic              cs_0,
  output logic              cs_1,
  output logic              we_n,
  output logic              oe_n,
  output logic              wr_bank,
  output logic              frame_done,
  output logic              overflow,
  output logic              underflow
);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [ADDR_W:0]   FRAME_LEN = (ADDR_W+1)'(FRAME_WORDS);

  typedef enum logic [1:0] {
    REC_IDLE   = 2'd0,
    REC_ARMED  = 2'd1,
    REC_ACTIVE = 2'd2,
    REC_DONE   = 2'd3
  } rec_state_t;

  typedef enum logic {
    PLAY_IDLE   = 1'b0,
    PLAY_ACTIVE = 1'b1
  } play_state_t;

  rec_state_t  rec_state;
  rec_state_t  rec_next;
  play_state_t play_state;
  play_state_t play_next;

  logic              phase;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_inflight;
  logic              last_write;
  logic              start_rec;
  logic              rec_flush;
  logic              play_restart;
  logic              play_flush;
  logic              write_go;
  logic              read_go;
  logic              swap;
  logic              bank_next;
  logic              play_chip;

  logic [DATA_W-1:0] wf_dout;
  logic              wf_empty;
  logic              wf_full;
  logic [DATA_W-1:0] rf_dout;
  logic              rf_empty;
  logic              rf_full;

`ifdef PING_PONG_EN
  // The bank flips only when a completed frame is handed to playback.
  assign swap      = frame_start && (rec_state == REC_DONE);
  assign bank_next = wr_bank ^ swap;
  assign play_chip = ~bank_next;
`else
  // Single-buffer build: everything lives on chip 0.
  assign swap      = 1'b0;
  assign bank_next = 1'b0;
  assign play_chip = 1'b0;
`endif

  assign wr_ready     = (rec_state == REC_ACTIVE) && !wf_full;
  assign start_rec    = (rec_next == REC_ACTIVE) && (rec_state != REC_ACTIVE);
  assign rec_flush    = start_rec || (rec_next == REC_IDLE);
  assign play_restart = frame_start && play_en;
  assign play_flush   = play_restart || (play_next == PLAY_IDLE);

  // The bus registers load on the edge before the slot they drive, so a
  // write slot is scheduled while phase is 1 and a read slot while it is 0.
  assign write_go = phase && (rec_state == REC_ACTIVE) && rec_en && !wf_empty;
  assign read_go  = !phase && (play_state == PLAY_ACTIVE) && play_en &&
                    !play_restart && !rf_full && ({1'b0, rd_ptr} < FRAME_LEN);

  sram_frame_sequencer_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_in (clk_in),
    .reset  (reset),
    .flush  (rec_flush),
    .push   (wr_valid && wr_ready),
    .pop    (write_go),
    .din    (wr_data),
    .dout   (wf_dout),
    .empty  (wf_empty),
    .full   (wf_full)
  );

  // A read already on the bus when playback restarts is stale and dropped.
  sram_frame_sequencer_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk_in (clk_in),
    .reset  (reset),
    .flush  (play_flush),
    .push   (rd_inflight && !play_restart),
    .pop    (rd_req),
    .din    (io_in),
    .dout   (rf_dout),
    .empty  (rf_empty),
    .full   (rf_full)
  );

  // Record FSM next-state; frame completion is detected on the last pop.
  always_comb begin
    rec_next   = rec_state;
    last_write = 1'b0;
    case (rec_state)
      REC_IDLE: begin
        if (rec_en) rec_next = REC_ARMED;
      end
      REC_ARMED: begin
        if (!rec_en)          rec_next = REC_IDLE;
        else if (frame_start) rec_next = REC_ACTIVE;
      end
      REC_ACTIVE: begin
        if (!rec_en) begin
          rec_next = REC_IDLE;
        end else if (write_go && (wr_ptr == LAST_WORD)) begin
          rec_next   = REC_DONE;
          last_write = 1'b1;
        end
      end
      REC_DONE: begin
        if (frame_start) rec_next = rec_en ? REC_ACTIVE : REC_IDLE;
      end
      default: rec_next = REC_IDLE;
    endcase
  end

  // Play FSM next-state: every frame_start re-arms while play_en is high.
  always_comb begin
    play_next = play_state;
    if (!play_en)         play_next = PLAY_IDLE;
    else if (frame_start) play_next = PLAY_ACTIVE;
  end

  // State registers, slot phase, bank and status flags.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rec_state  <= REC_IDLE;
      play_state <= PLAY_IDLE;
      phase      <= 1'b0;
      wr_bank    <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rec_state  <= rec_next;
      play_state <= play_next;
      phase      <= ~phase;
      wr_bank    <= bank_next;
      frame_done <= last_write;
      if (wr_valid && (rec_state == REC_ACTIVE) && wf_full) overflow <= 1'b1;
    end
  end

  // Frame pointers: restart on frame entry, advance once per issued slot.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (start_rec)     wr_ptr <= '0;
      else if (write_go) wr_ptr <= wr_ptr + 1'b1;
      if (play_restart)  rd_ptr <= '0;
      else if (read_go)  rd_ptr <= rd_ptr + 1'b1;
      rd_inflight <= read_go;
    end
  end

  // Registered SRAM bus; an unused slot deselects both chips and the bus.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      addr   <= '0;
      io_out <= '0;
      io_oe  <= 1'b0;
      cs_0   <= 1'b1;
      cs_1   <= 1'b1;
      we_n   <= 1'b1;
      oe_n   <= 1'b1;
    end else begin
      io_oe <= 1'b0;
      cs_0  <= 1'b1;
      cs_1  <= 1'b1;
      we_n  <= 1'b1;
      oe_n  <= 1'b1;
      if (write_go) begin
        addr   <= wr_ptr;
        io_out <= wf_dout;
        io_oe  <= 1'b1;
        we_n   <= 1'b0;
        if (bank_next) cs_1 <= 1'b0;
        else           cs_0 <= 1'b0;
      end else if (read_go) begin
        addr <= rd_ptr;
        oe_n <= 1'b0;
        if (play_chip) cs_1 <= 1'b0;
        else           cs_0 <= 1'b0;
      end
    end
  end

  // Display-side pop: an empty FIFO returns zero and flags underflow.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= rf_empty ? '0 : rf_dout;
        if (rf_empty) underflow <= 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sram_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_frame_sequencer
//  Purpose  : Scoreboard bench for sram_frame_sequencer with a two-chip SRAM
//             model. Honors PING_PONG_EN for the expected bank assignment.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_frame_sequencer;
  localparam int ADDR_W      = 21;
  localparam int DATA_W      = 8;
  localparam int FRAME_WORDS = 16;
  localparam int FIFO_DEPTH  = 4;

`ifdef PING_PONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  logic              clk_in      = 1'b0;
  logic              reset       = 1'b1;
  logic              rec_en      = 1'b0;
  logic              play_en     = 1'b0;
  logic              frame_start = 1'b0;
  logic [DATA_W-1:0] wr_data     = '0;
  logic              wr_valid    = 1'b0;
  logic              rd_req      = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] io_out;
  logic              io_oe;
  logic [DATA_W-1:0] io_in;
  logic              cs_0;
  logic              cs_1;
  logic              we_n;
  logic              oe_n;
  logic              wr_bank;
  logic              frame_done;
  logic              overflow;
  logic              underflow;

  sram_frame_sequencer #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .FRAME_WORDS (FRAME_WORDS),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .rec_en      (rec_en),
    .play_en     (play_en),
    .frame_start (frame_start),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .rd_req      (rd_req),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .addr        (addr),
    .io_out      (io_out),
    .io_oe       (io_oe),
    .io_in       (io_in),
    .cs_0        (cs_0),
    .cs_1        (cs_1),
    .we_n        (we_n),
    .oe_n        (oe_n),
    .wr_bank     (wr_bank),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk_in = ~clk_in;

  // Two-chip asynchronous SRAM model.
  logic [DATA_W-1:0] mem0 [0:31];
  logic [DATA_W-1:0] mem1 [0:31];

  assign io_in = (!oe_n && !cs_0) ? mem0[addr[4:0]] :
                 (!oe_n && !cs_1) ? mem1[addr[4:0]] : 8'h00;

  always @(posedge clk_in) begin
    if (!we_n && io_oe) begin
      if (!cs_0) mem0[addr[4:0]] <= io_out;
      if (!cs_1) mem1[addr[4:0]] <= io_out;
    end
  end

  // Scoreboard queues.
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              c0;
    logic              c1;
  } wr_exp_t;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic              c0;
    logic              c1;
  } rs_exp_t;

  wr_exp_t           wq [$];
  rs_exp_t           raq [$];
  logic [DATA_W-1:0] rq [$];

  int checks   = 0;
  int errors   = 0;
  bit chk_wr   = 1'b0;
  bit chk_rd   = 1'b0;
  int wr_slots = 0;
  int fd_count = 0;

  wr_exp_t           me;
  rs_exp_t           mr;
  logic [DATA_W-1:0] md;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk_in) begin
    #1;
    if (!reset) begin
      check("cs_exclusive", int'(cs_0 | cs_1), 1);
      check("we_oe_exclusive", int'(we_n | oe_n), 1);
      if (!we_n) begin
        wr_slots++;
        check("write_io_oe", int'(io_oe), 1);
        if (chk_wr) begin
          if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL write_unexpected actual addr=%0h required no write", addr);
          end else begin
            me = wq.pop_front();
            check("write_addr", int'(addr), int'(me.a));
            check("write_data", int'(io_out), int'(me.d));
            check("write_cs_0", int'(cs_0), int'(me.c0));
            check("write_cs_1", int'(cs_1), int'(me.c1));
          end
        end
      end
      if (!oe_n) begin
        check("read_io_oe", int'(io_oe), 0);
        if (chk_rd) begin
          if (raq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL read_unexpected actual addr=%0h required no read", addr);
          end else begin
            mr = raq.pop_front();
            check("read_addr", int'(addr), int'(mr.a));
            check("read_cs_0", int'(cs_0), int'(mr.c0));
            check("read_cs_1", int'(cs_1), int'(mr.c1));
          end
        end
      end
      if (rd_valid) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_valid_unexpected actual data=%0h required no valid", rd_data);
        end else begin
          md = rq.pop_front();
          check("rd_data", int'(rd_data), int'(md));
        end
      end
      if (frame_done) fd_count++;
    end
  end

  int  acc;
  bit  saw_not_ready;

  initial begin
    // Reset state
    tick(3);
    check("rst_addr", int'(addr), 0);
    check("rst_io_out", int'(io_out), 0);
    check("rst_io_oe", int'(io_oe), 0);
    check("rst_cs_0", int'(cs_0), 1);
    check("rst_cs_1", int'(cs_1), 1);
    check("rst_we_n", int'(we_n), 1);
    check("rst_oe_n", int'(oe_n), 1);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_wr_bank", int'(wr_bank), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_underflow", int'(underflow), 0);
    check("rst_wr_ready", int'(wr_ready), 0);
    reset = 1'b0;

    // Record one full frame, pixels 0x00..0x0F on chip 0
    rec_en = 1'b1;
    tick(2);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    chk_wr = 1'b1;
    for (int i = 0; i < FRAME_WORDS; i++) begin
      check("t1_wr_ready", int'(wr_ready), 1);
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      wq.push_back('{a: ADDR_W'(i), d: 8'(i), c0: 1'b0, c1: 1'b1});
      tick(1);
      wr_valid = 1'b0;
      tick(1);
    end
    tick(8);
    check("t1_writes_done", wq.size(), 0);
    check("t1_frame_done_count", fd_count, 1);
    check("t1_overflow", int'(overflow), 0);
    check("t1_wr_bank", int'(wr_bank), 0);

    // Play the recorded frame back from chip 0
    play_en     = 1'b1;
    frame_start = 1'b1;
    chk_rd      = 1'b1;
    for (int i = 0; i < FRAME_WORDS; i++)
      raq.push_back('{a: ADDR_W'(i), c0: 1'b0, c1: 1'b1});
    tick(1);
    frame_start = 1'b0;
    check("t2_wr_bank", int'(wr_bank), int'(PP));
    tick(7);
    for (int i = 0; i < FRAME_WORDS; i++) begin
      rd_req = 1'b1;
      rq.push_back(8'(i));
      tick(1);
      rd_req = 1'b0;
      tick(1);
    end
    tick(4);
    check("t2_reads_done", rq.size(), 0);
    check("t2_read_slots_done", raq.size(), 0);
    check("t2_underflow", int'(underflow), 0);
    chk_rd = 1'b0;

    // Back-to-back capture overflows the write FIFO
    chk_wr        = 1'b0;
    wr_slots      = 0;
    acc           = 0;
    saw_not_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h80 + i);
      if (wr_ready) acc++;
      else          saw_not_ready = 1'b1;
      tick(1);
    end
    wr_valid = 1'b0;
    tick(12);
    check("t3_wr_ready_dropped", int'(saw_not_ready), 1);
    check("t3_overflow", int'(overflow), 1);
    check("t3_written_eq_accepted", wr_slots, acc);
    check("t3_written_lt_20", int'(wr_slots < 20), 1);
    check("t3_frame_done_count", fd_count, 1);

    // Pop before the first read slot of a frame has completed
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    rd_req      = 1'b1;
    rq.push_back(8'h00);
    tick(1);
    rd_req = 1'b0;
    tick(2);
    check("t4_underflow", int'(underflow), 1);
    check("t4_rd_consumed", rq.size(), 0);
    check("t4_wr_bank", int'(wr_bank), int'(PP));
    play_en = 1'b0;
    tick(4);

    // Partial frame abandoned at word 7
    rec_en = 1'b0;
    tick(2);
    rec_en = 1'b1;
    tick(2);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    chk_wr = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h40 + i);
      wq.push_back('{a: ADDR_W'(i), d: 8'(8'h40 + i), c0: PP, c1: ~PP});
      tick(1);
      wr_valid = 1'b0;
      tick(1);
    end
    tick(4);
    check("t5_partial_written", wq.size(), 0);
    rec_en = 1'b0;
    tick(2);
    wr_valid = 1'b1;
    wr_data  = 8'hFF;
    tick(1);
    wr_valid    = 1'b0;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(3);
    check("t5_wr_bank_unchanged", int'(wr_bank), int'(PP));
    check("t5_no_frame_done", fd_count, 1);

    // Reset in the middle of an active frame
    chk_wr  = 1'b0;
    rec_en  = 1'b1;
    play_en = 1'b1;
    tick(2);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h20 + i);
      tick(1);
    end
    reset = 1'b1;
    tick(1);
    check("t6_cs_0", int'(cs_0), 1);
    check("t6_cs_1", int'(cs_1), 1);
    check("t6_we_n", int'(we_n), 1);
    check("t6_oe_n", int'(oe_n), 1);
    check("t6_io_oe", int'(io_oe), 0);
    check("t6_addr", int'(addr), 0);
    check("t6_overflow", int'(overflow), 0);
    check("t6_underflow", int'(underflow), 0);
    check("t6_wr_bank", int'(wr_bank), 0);
    check("t6_frame_done", int'(frame_done), 0);
    check("t6_wr_ready", int'(wr_ready), 0);
    wr_valid = 1'b0;
    rec_en   = 1'b0;
    play_en  = 1'b0;
    reset    = 1'b0;
    tick(3);
    check("end_wr_queue", wq.size(), 0);
    check("end_rd_queue", rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
